// File: rtl/io_irq_pkg.sv
// Shared definitions for the io_irq interrupt controller: register offsets,
// handshake state encoding, source indices and STAT bit positions.
package io_irq_pkg;

  localparam logic [1:0] IRQ_MASK = 2'd0;
  localparam logic [1:0] IRQ_PEND = 2'd1;
  localparam logic [1:0] IRQ_STAT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_t;

  localparam int IRQ_TIMER = 0;
  localparam int IRQ_KBD   = 1;

  localparam int STAT_GIE     = 7;
  localparam int STAT_INSVC   = 6;
  localparam int STAT_IDX_LSB = 0;

  function automatic logic [7:0] stat_word(input logic gie, input logic insvc,
                                           input logic [2:0] idx);
    logic [7:0] s;
    s = '0;
    s[STAT_GIE] = gie;
    s[STAT_INSVC] = insvc;
    s[STAT_IDX_LSB +: 3] = idx;
    return s;
  endfunction

endpackage

// File: rtl/io_irq_prio.sv
// Lowest-index-wins priority encoder over the eligible interrupt sources.
module io_irq_prio #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req_i,
  output logic            valid_o,
  output logic [2:0]      idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/io_irq.sv
// Port-mapped interrupt controller: MASK/PEND/STAT registers, fixed-priority
// arbitration and an intr/ack/reti handshake. Optional macro IO_IRQ_EDGE_EN.
module io_irq
  import io_irq_pkg::*;
#(
  parameter int          NSRC     = 4,
  parameter logic [15:0] BASE     = 16'h24,
  parameter logic [7:0]  VEC_BASE = 8'h01
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [15:0]     a,
  input  logic [7:0]      o,
  input  logic            r,
  input  logic            w,
  output logic [7:0]      p,
  input  logic [NSRC-1:0] irq_src,
  output logic            intr,
  output logic [7:0]      irq_vec,
  input  logic            irq_ack,
  input  logic            irq_reti,
  output irq_state_t      dbg_state
);

  // Handshake: intr is held while in REQ; a one-cycle irq_ack seen while intr
  // is high (and the latched source still eligible) completes the transfer.
  // irq_reti is only honoured in SVC; both strobes are ignored elsewhere.

  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic            gie_q, gie_d;
  irq_state_t      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            intr_q, intr_d;
  logic [7:0]      vec_q, vec_d;

  logic [15:0]     off16;
  logic            hit;
  logic [1:0]      off;
  logic            wr_mask, wr_pend, wr_stat;
  logic [NSRC-1:0] evt, elig, cur_oh, ack_clr, w1c;
  logic            cur_elig, win_valid;
  logic [2:0]      win_idx;

  assign off16   = a - BASE;
  assign hit     = off16 < 16'd3;
  assign off     = off16[1:0];
  assign wr_mask = w && hit && (off == IRQ_MASK);
  assign wr_pend = w && hit && (off == IRQ_PEND);
  assign wr_stat = w && hit && (off == IRQ_STAT);

`ifdef IO_IRQ_EDGE_EN
  logic [NSRC-1:0] src_q, hist_q;

  // The extra register stage costs one cycle of latency but keeps the edge
  // detector free of any combinational path from irq_src to PEND.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_q  <= '0;
      hist_q <= '0;
    end else begin
      src_q  <= irq_src;
      hist_q <= src_q;
    end
  end

  assign evt = src_q & ~hist_q;
`else
  assign evt = irq_src;
`endif

  assign elig     = pend_q & mask_q & {NSRC{gie_q}};
  assign cur_oh   = NSRC'(1) << idx_q;
  assign cur_elig = |(elig & cur_oh);
  assign w1c      = wr_pend ? o[NSRC-1:0] : '0;

  io_irq_prio #(.NSRC(NSRC)) u_prio (
    .req_i   (elig),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ack_clr = '0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          idx_d   = win_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        // The winner stays fixed; a lost source drops the request outright.
        if (!cur_elig) begin
          state_d = IDLE;
        end else if (irq_ack) begin
          ack_clr = cur_oh;
          state_d = SVC;
        end
      end
      SVC: begin
        if (irq_reti) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mask_d = wr_mask ? o[NSRC-1:0] : mask_q;
    gie_d  = wr_stat ? o[STAT_GIE] : gie_q;
    pend_d = (pend_q & ~w1c & ~ack_clr) | evt;
    intr_d = (state_d == REQ);
    vec_d  = intr_d ? (VEC_BASE + 8'(idx_d)) : 8'h00;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '0;
      pend_q  <= '0;
      gie_q   <= 1'b0;
      state_q <= IDLE;
      idx_q   <= '0;
      intr_q  <= 1'b0;
      vec_q   <= 8'h00;
    end else begin
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      gie_q   <= gie_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      intr_q  <= intr_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    p = 8'h00;
    if (hit) begin
      case (off)
        IRQ_MASK: p = 8'(mask_q);
        IRQ_PEND: p = 8'(pend_q);
        IRQ_STAT: p = stat_word(gie_q, state_q == SVC, idx_q);
        default:  p = 8'h00;
      endcase
    end
  end

  assign intr      = intr_q;
  assign irq_vec   = vec_q;
  assign dbg_state = state_q;

  // Reads are side-effect free, so the read strobe carries no information here.
  logic unused_ok;
  assign unused_ok = ^{r, o};

endmodule

// File: tb/tb_io_irq.sv
// Directed bench for io_irq: a cycle model of the register/handshake rules is
// compared every cycle, plus literal checks at the interesting points.
module tb_io_irq;
  import io_irq_pkg::*;

  localparam logic [15:0] BASE = 16'h24;
  localparam logic [7:0]  VECB = 8'h01;
`ifdef IO_IRQ_EDGE_EN
  localparam int EXTRA = 1;
  localparam bit EDGE  = 1'b1;
`else
  localparam int EXTRA = 0;
  localparam bit EDGE  = 1'b0;
`endif

  logic        clock, reset_n;
  logic [15:0] a;
  logic [7:0]  o, p, irq_vec;
  logic        r, w, intr, irq_ack, irq_reti;
  logic [3:0]  irq_src;
  irq_state_t  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  io_irq #(.NSRC(4), .BASE(BASE), .VEC_BASE(VECB)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .a         (a),
    .o         (o),
    .r         (r),
    .w         (w),
    .p         (p),
    .irq_src   (irq_src),
    .intr      (intr),
    .irq_vec   (irq_vec),
    .irq_ack   (irq_ack),
    .irq_reti  (irq_reti),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [3:0] m_mask, m_pend, m_s1, m_s2;
  logic       m_gie, m_req, m_svc;
  logic [1:0] m_idx;
  logic [3:0] m_ev, m_el, m_clr;
  logic [1:0] m_win;
  logic       m_win_ok;

  always_comb begin
    m_ev = EDGE ? (m_s1 & ~m_s2) : irq_src;
    m_el = m_gie ? (m_pend & m_mask) : 4'h0;
    m_win_ok = (m_el != 4'h0);
    m_win = 2'd0;
    for (int i = 3; i >= 0; i--) if (m_el[i]) m_win = 2'(i);
    m_clr = 4'h0;
    if (m_req && m_el[m_idx] && irq_ack) m_clr[m_idx] = 1'b1;
    if (w && a == BASE + 16'd1) m_clr = m_clr | o[3:0];
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mask <= 4'h0; m_pend <= 4'h0; m_s1 <= 4'h0; m_s2 <= 4'h0;
      m_gie <= 1'b0; m_req <= 1'b0; m_svc <= 1'b0; m_idx <= 2'd0;
    end else begin
      if (m_req) begin
        if (!m_el[m_idx]) m_req <= 1'b0;
        else if (irq_ack) begin m_req <= 1'b0; m_svc <= 1'b1; end
      end else if (m_svc) begin
        if (irq_reti) m_svc <= 1'b0;
      end else if (m_win_ok) begin
        m_req <= 1'b1;
        m_idx <= m_win;
      end
      if (w && a == BASE) m_mask <= o[3:0];
      if (w && a == BASE + 16'd2) m_gie <= o[7];
      m_pend <= (m_pend & ~m_clr) | m_ev;
      m_s2 <= m_s1;
      m_s1 <= irq_src;
    end
  end

  function automatic logic [7:0] exp_p();
    if (a == BASE) return {4'h0, m_mask};
    if (a == BASE + 16'd1) return {4'h0, m_pend};
    if (a == BASE + 16'd2) return {m_gie, m_svc, 4'h0, m_idx};
    return 8'h00;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    a = addr; o = data; w = 1'b1;
    tick(1);
    w = 1'b0; a = 16'h0000; o = 8'h00;
  endtask

  task automatic rd(input string nm, input logic [15:0] addr, input logic [7:0] exp);
    a = addr; r = 1'b1;
    #2;
    chk(nm, p, exp);
    tick(1);
    r = 1'b0; a = 16'h0000;
  endtask

  task automatic pulse(input logic [3:0] s);
    irq_src = s;
    tick(1);
    irq_src = 4'h0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic reti();
    irq_reti = 1'b1;
    tick(1);
    irq_reti = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; a = 16'h0000; o = 8'h00; r = 1'b0; w = 1'b0;
    irq_src = 4'h0; irq_ack = 1'b0; irq_reti = 1'b0;

    fork
      forever begin
        @(negedge clock);
        if (reset_n) begin
          chk("cyc_intr", {7'h0, intr}, {7'h0, m_req});
          chk("cyc_vec", irq_vec, m_req ? (VECB + {6'h0, m_idx}) : 8'h00);
          chk("cyc_p", p, exp_p());
        end
      end
    join_none

    tick(2);
    chk("rst_intr", {7'h0, intr}, 8'h00);
    chk("rst_vec", irq_vec, 8'h00);
    reset_n = 1'b1;
    tick(1);
    rd("rst_mask", BASE, 8'h00);
    rd("rst_pend", BASE + 16'd1, 8'h00);
    rd("rst_stat", BASE + 16'd2, 8'h00);
    rd("unowned_lo", BASE - 16'd1, 8'h00);

    // single source, full handshake
    wr(BASE, 8'h03);
    wr(BASE + 16'd2, 8'h80);
    rd("mask_rb", BASE, 8'h03);
    rd("unowned_hi", BASE + 16'd3, 8'h00);
    pulse(4'h1);
    chk("t1_intr_n1", {7'h0, intr}, 8'h00);
    tick(EXTRA);
    chk("t1_intr_early", {7'h0, intr}, 8'h00);
    tick(1);
    chk("t1_intr", {7'h0, intr}, 8'h01);
    chk("t1_vec", irq_vec, 8'h01);
    ack();
    chk("t1_intr_after_ack", {7'h0, intr}, 8'h00);
    chk("t1_model_pend", {4'h0, m_pend}, 8'h00);
    rd("t1_pend", BASE + 16'd1, 8'h00);
    rd("t1_stat_svc", BASE + 16'd2, 8'hC0);
    reti();
    rd("t1_stat_idle", BASE + 16'd2, 8'h80);

    // two sources at once: lower index first
    pulse(4'h3);
    tick(EXTRA);
    rd("t2_pend3", BASE + 16'd1, 8'h03);
    chk("t2_intr", {7'h0, intr}, 8'h01);
    chk("t2_vec0", irq_vec, 8'h01);
    ack();
    rd("t2_pend2", BASE + 16'd1, 8'h02);
    rd("t2_stat0", BASE + 16'd2, 8'hC0);
    reti();
    tick(1);
    chk("t2_intr2", {7'h0, intr}, 8'h01);
    chk("t2_vec1", irq_vec, 8'h02);
    ack();
    rd("t2_stat1", BASE + 16'd2, 8'hC1);
    rd("t2_pend0", BASE + 16'd1, 8'h00);
    reti();

    // masking and W1C drop while requesting
    wr(BASE, 8'h00);
    pulse(4'h2);
    tick(1 + EXTRA);
    rd("t3_pend", BASE + 16'd1, 8'h02);
    chk("t3_masked_intr", {7'h0, intr}, 8'h00);
    wr(BASE, 8'h02);
    chk("t3_intr_wait", {7'h0, intr}, 8'h00);
    tick(1);
    chk("t3_intr", {7'h0, intr}, 8'h01);
    chk("t3_vec", irq_vec, 8'h02);
    wr(BASE + 16'd1, 8'h02);
    chk("t3_intr_hold", {7'h0, intr}, 8'h01);
    tick(1);
    chk("t3_intr_drop", {7'h0, intr}, 8'h00);
    rd("t3_stat", BASE + 16'd2, 8'h81);
    rd("t3_pend0", BASE + 16'd1, 8'h00);

    // set wins over a same-cycle W1C clear
    irq_src = 4'h1;
    if (EDGE) begin
      tick(1);
      irq_src = 4'h0;
    end
    a = BASE + 16'd1; o = 8'h01; w = 1'b1;
    tick(1);
    w = 1'b0; a = 16'h0000; o = 8'h00; irq_src = 4'h0;
    rd("t4_pend_kept", BASE + 16'd1, 8'h01);
    chk("t4_model_pend", {4'h0, m_pend}, 8'h01);
    wr(BASE + 16'd1, 8'h01);
    rd("t4_pend_clr", BASE + 16'd1, 8'h00);

    // asynchronous reset while requesting
    wr(BASE, 8'h01);
    pulse(4'h1);
    tick(1 + EXTRA);
    chk("t5_intr", {7'h0, intr}, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_intr", {7'h0, intr}, 8'h00);
    chk("t5_async_vec", irq_vec, 8'h00);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    rd("t5_mask", BASE, 8'h00);
    rd("t5_pend", BASE + 16'd1, 8'h00);
    rd("t5_stat", BASE + 16'd2, 8'h00);

    // level-held source for 10 cycles
    wr(BASE, 8'h02);
    wr(BASE + 16'd2, 8'h80);
    irq_src = 4'h2;
    tick(2 + EXTRA);
    chk("t6_intr1", {7'h0, intr}, 8'h01);
    ack();
    reti();
    tick(1);
    chk("t6_intr2", {7'h0, intr}, EDGE ? 8'h00 : 8'h01);
    tick(5 - EXTRA);
    irq_src = 4'h0;
    if (!EDGE) begin
      ack();
      reti();
    end
    tick(3);
    chk("t6_quiet", {7'h0, intr}, 8'h00);
    rd("t6_pend", BASE + 16'd1, 8'h00);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/io_irq.md
# io_irq

Interrupt controller for the AVR system's I/O port space. It latches event requests from peripherals (100 Hz timer tick, keyboard "key received", spare sources) into a pending register and gates them with a mask. It arbitrates the pending sources by fixed priority and sequences a request/acknowledge/return handshake with the CPU core. It is a slave on the same `a`/`o`/`r`/`w` port bus as the other port blocks, and drives its read data onto a zero-when-unaddressed bus that the top level ORs.

## Interface
Parameters:
- `NSRC`, 4: number of interrupt sources, 1..8.
- `BASE`, 16'h24: first port address; the block owns `BASE`..`BASE+2`.
- `VEC_BASE`, 8'h01: vector number reported for source 0.

Ports:
- `clock`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `a`, in, 16: port address.
- `o`, in, 8: port write data.
- `r`, in, 1: port read strobe, one cycle.
- `w`, in, 1: port write strobe, one cycle.
- `p`, out, 8: port read data. Combinational. 8'h00 when `a` is not owned.
- `irq_src`, in, NSRC: source requests. Bit 0 is the timer tick; bit 1 is the keyboard `kdone`.
- `intr`, out, 1: interrupt request to the core.
- `irq_vec`, out, 8: vector number. Valid while `intr` is high.
- `irq_ack`, in, 1: core accepts the interrupt. One-cycle pulse.
- `irq_reti`, in, 1: core executed RETI. One-cycle pulse.

## Operation
- Registers:
  - `BASE+0` MASK (RW): bits [NSRC-1:0]; upper bits read 0.
  - `BASE+1` PEND: read returns pending bits; a write clears every bit written as 1.
  - `BASE+2` STAT: bit 7 GIE (RW); bit 6 in-service (RO); bits [2:0] active source index (RO). Writes affect bit 7 only.
- Pending: a source event sets its PEND bit. Set has priority over a same-cycle W1C clear or ack-clear.
- Eligible set = PEND & MASK, qualified by GIE. The winner is the lowest eligible index.
- FSM `IDLE` → `REQ` → `SVC` → `IDLE`:
  - `IDLE`: when the eligible set is non-zero, latch the winner index and go to `REQ`.
  - `REQ`: `intr`=1, `irq_vec`=VEC_BASE+index.
    - `irq_ack` → clear that PEND bit, set in-service, go to `SVC`.
    - If the latched source stops being eligible (masked, cleared, GIE=0) before ack → back to `IDLE`, `intr`=0. No re-arbitration inside `REQ`; the winner is fixed until ack or drop.
  - `SVC`: `intr`=0, no nesting. `irq_reti` → clear in-service, go to `IDLE`.
- `irq_ack` outside `REQ` and `irq_reti` outside `SVC` are ignored.
- Reset values: MASK=0, PEND=0, GIE=0, state `IDLE`, index=0, `intr`=0, `irq_vec`=8'h00.

## Timing
- Source event at edge N → PEND bit visible at N+1 → `REQ` entered and `intr` high at N+2, provided it is eligible. `intr` and `irq_vec` are registered.
- `irq_ack` sampled at edge M → `intr` low from M+1; the PEND bit is clear at M+1.
- `irq_reti` at edge K → `IDLE` at K+1. A still-pending eligible source raises `intr` at K+2.
- Register writes take effect at the write edge. Reads are combinational in the same cycle as `r`; reads have no side effects.
- A `reset_n` assertion mid-handshake drops `intr` immediately (asynchronous) and returns all state to the reset values.

## Configuration
- `IO_IRQ_EDGE_EN` defined:
  - Each `irq_src` bit passes through a registered rising-edge detector; only a 0→1 transition sets PEND.
  - A source held high sets PEND once.
  - The detector history register resets to 0.
  - Adds one cycle: an `intr` raised by a source is high at N+3.
- Undefined:
  - `irq_src` is treated as a pulse; every high cycle sets PEND.
  - A level-held source re-pends immediately after a clear.

## Structure
- Package `io_irq_pkg` holds:
  - Register offsets (`IRQ_MASK`=0, `IRQ_PEND`=1, `IRQ_STAT`=2).
  - The state enum (`IDLE`, `REQ`, `SVC`).
  - Source index constants (`IRQ_TIMER`=0, `IRQ_KBD`=1).
  - STAT bit positions.
- One sub-module, `io_irq_prio`: a combinational, NSRC-wide lowest-index priority encoder that outputs a valid flag and a 3-bit index.

## Test plan
- Reset: MASK=0x03, GIE=1; pulse `irq_src`[0] one cycle → `intr` at +2, `irq_vec`=0x01. Ack → PEND reads 0x00, STAT reads 0xC0. RETI → STAT 0x80.
- Pulse sources 0 and 1 in the same cycle → vector 0x01 first. After ack+RETI, vector 0x02; the PEND sequence reads 0x03 → 0x02 → 0x00.
- MASK=0: pulse source 1 → PEND=0x02, `intr` stays low. Write MASK=0x02 → `intr` high 1 cycle later. Write PEND=0x02 while in `REQ` → `intr` drops, no ack needed.
- Source 0 pulse in the same cycle as the W1C write 0x01 to PEND → PEND bit 0 remains 1.
- Assert `reset_n` low during `REQ` → `intr`=0 with no clock edge; after release, MASK/PEND/STAT read 0.
- With `IO_IRQ_EDGE_EN`: hold `irq_src`[1] high for 10 cycles, ack+RETI → no second interrupt. Without it, a second `intr` follows.
